// File: rtl/prio_grant_encoder.sv
// prio_grant_encoder: registered priority / round-robin request encoder.
// A request vector is turned into a binary index and a one-hot grant. Once
// issued, the grant is frozen until the consumer acks it. An ack can be
// followed on the same edge by the next grant, so there is no idle cycle
// between grants.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant outstanding; valid=0, enc_out=0, grant=0
// GRANT | grant issued and frozen until ack; valid=1
module prio_grant_encoder #(
   parameter int OUT_SIZE = 4,
   parameter int IN_SIZE  = 1 << OUT_SIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                mode,
   input  logic [IN_SIZE-1:0]  in,
   input  logic                ack,
   output logic [OUT_SIZE-1:0] enc_out,
   output logic [IN_SIZE-1:0]  grant,
   output logic                valid
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [OUT_SIZE-1:0] LAST_IDX = OUT_SIZE'(IN_SIZE - 1);

   state_t              state, state_nxt;
   logic [OUT_SIZE-1:0] ptr, ptr_nxt;
   logic [OUT_SIZE-1:0] enc_nxt;
   logic [IN_SIZE-1:0]  grant_nxt;
   logic [OUT_SIZE-1:0] win;
   logic                found;
   logic                decide;

   // State, pointer and output registers. Outputs are registered so there is
   // no combinational path from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         enc_out <= '0;
         grant   <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         enc_out <= enc_nxt;
         grant   <= grant_nxt;
      end
   end

   assign valid = (state == GRANT);

   // Next state, pointer advance and winner selection. The pointer is updated
   // before the winner search so a back-to-back grant sees the new pointer.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      enc_nxt   = enc_out;
      grant_nxt = grant;
      decide    = 1'b0;
      win       = '0;
      found     = 1'b0;

      case (state)
         IDLE: begin
            decide = enable && (|in);
         end
         GRANT: begin
            if (ack) begin
               if (mode) begin
                  ptr_nxt = (enc_out == LAST_IDX) ? '0 : enc_out + OUT_SIZE'(1);
               end
               decide = enable && (|in);
               if (!decide) begin
                  state_nxt = IDLE;
                  enc_nxt   = '0;
                  grant_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            enc_nxt   = '0;
            grant_nxt = '0;
         end
      endcase

      // Fixed mode treats the pointer as 0; round-robin searches at/above ptr
      // first, then wraps to the lowest set index.
      for (int i = 0; i < IN_SIZE; i++) begin
         if (!found && in[i] && (!mode || (OUT_SIZE'(i) >= ptr_nxt))) begin
            win   = OUT_SIZE'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < IN_SIZE; i++) begin
         if (!found && in[i]) begin
            win   = OUT_SIZE'(i);
            found = 1'b1;
         end
      end

      if (decide) begin
         state_nxt = GRANT;
         enc_nxt   = win;
         grant_nxt = IN_SIZE'(1) << win;
      end
   end

endmodule

// File: tb/tb_prio_grant_encoder.sv
// Directed bench for prio_grant_encoder: a 16-input instance for the main
// scenarios and a 5-input instance for the non-power-of-two wrap.
module tb_prio_grant_encoder;

   logic        clk;
   logic        rst_n;

   logic        enable, mode, ack;
   logic [15:0] in;
   logic [3:0]  enc_out;
   logic [15:0] grant;
   logic        valid;

   logic        enable5, mode5, ack5;
   logic [4:0]  in5;
   logic [2:0]  enc_out5;
   logic [4:0]  grant5;
   logic        valid5;

   int tests_run;
   int tests_failed;

   prio_grant_encoder #(.OUT_SIZE(4), .IN_SIZE(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in(in),
      .ack(ack), .enc_out(enc_out), .grant(grant), .valid(valid)
   );

   prio_grant_encoder #(.OUT_SIZE(3), .IN_SIZE(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .enable(enable5), .mode(mode5), .in(in5),
      .ack(ack5), .enc_out(enc_out5), .grant(grant5), .valid(valid5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0; mode = 1'b0; ack = 1'b0; in = 16'h0000;
      enable5 = 1'b0; mode5 = 1'b0; ack5 = 1'b0; in5 = 5'h00;
      #12;
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b0, 4'd0, 16'h0000}) begin
         tests_failed++;
         $display("FAIL reset_state: got v=%0b e=%0d g=%h want v=0 e=0 g=0000",
                  valid, enc_out, grant);
      end
      tests_run++;
      if ({valid5, enc_out5, grant5} !== {1'b0, 3'd0, 5'h00}) begin
         tests_failed++;
         $display("FAIL reset_state5: got v=%0b e=%0d g=%h want v=0 e=0 g=00",
                  valid5, enc_out5, grant5);
      end
      #2 rst_n = 1'b1;
      step();
   endtask

   task automatic test_fixed();
      mode = 1'b0; enable = 1'b1; ack = 1'b0; in = 16'h0028;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd3, 16'h0008}) begin
         tests_failed++;
         $display("FAIL fixed_first: got v=%0b e=%0d g=%h want v=1 e=3 g=0008",
                  valid, enc_out, grant);
      end
      in = 16'h0001;
      for (int c = 0; c < 5; c++) begin
         step();
         tests_run++;
         if ({valid, enc_out, grant} !== {1'b1, 4'd3, 16'h0008}) begin
            tests_failed++;
            $display("FAIL fixed_hold[%0d]: got v=%0b e=%0d g=%h want v=1 e=3 g=0008",
                     c, valid, enc_out, grant);
         end
      end
      ack = 1'b1;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd0, 16'h0001}) begin
         tests_failed++;
         $display("FAIL fixed_next: got v=%0b e=%0d g=%h want v=1 e=0 g=0001",
                  valid, enc_out, grant);
      end
      enable = 1'b0;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b0, 4'd0, 16'h0000}) begin
         tests_failed++;
         $display("FAIL fixed_release: got v=%0b e=%0d g=%h want v=0 e=0 g=0000",
                  valid, enc_out, grant);
      end
      ack = 1'b0;
   endtask

   task automatic test_rr_alternate();
      logic [3:0] exp_e [4];
      exp_e[0] = 4'd0; exp_e[1] = 4'd15; exp_e[2] = 4'd0; exp_e[3] = 4'd15;
      mode = 1'b1; enable = 1'b1; ack = 1'b1; in = 16'h8001;
      for (int c = 0; c < 4; c++) begin
         step();
         tests_run++;
         if ({valid, enc_out, grant} !== {1'b1, exp_e[c], 16'(16'h0001 << exp_e[c])}) begin
            tests_failed++;
            $display("FAIL rr_alt[%0d]: got v=%0b e=%0d g=%h want v=1 e=%0d",
                     c, valid, enc_out, grant, exp_e[c]);
         end
      end
   endtask

   // Continues from enc_out=15 left by test_rr_alternate.
   task automatic test_rr_wrap();
      in = 16'h4002; ack = 1'b1;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd1, 16'h0002}) begin
         tests_failed++;
         $display("FAIL rr_wrap_a: got v=%0b e=%0d g=%h want v=1 e=1 g=0002",
                  valid, enc_out, grant);
      end
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd14, 16'h4000}) begin
         tests_failed++;
         $display("FAIL rr_wrap_b: got v=%0b e=%0d g=%h want v=1 e=14 g=4000",
                  valid, enc_out, grant);
      end
      enable = 1'b0;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b0, 4'd0, 16'h0000}) begin
         tests_failed++;
         $display("FAIL rr_wrap_release: got v=%0b e=%0d g=%h want v=0 e=0 g=0000",
                  valid, enc_out, grant);
      end
      ack = 1'b0;
   endtask

   task automatic test_enable();
      mode = 1'b0; enable = 1'b0; ack = 1'b0; in = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         step();
         tests_run++;
         if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_gate[%0d]: got v=%0b want v=0", c, valid);
         end
      end
      enable = 1'b1;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd0, 16'h0001}) begin
         tests_failed++;
         $display("FAIL enable_raise: got v=%0b e=%0d g=%h want v=1 e=0 g=0001",
                  valid, enc_out, grant);
      end
      enable = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         tests_run++;
         if ({valid, enc_out, grant} !== {1'b1, 4'd0, 16'h0001}) begin
            tests_failed++;
            $display("FAIL enable_drop_hold[%0d]: got v=%0b e=%0d g=%h want v=1 e=0 g=0001",
                     c, valid, enc_out, grant);
         end
      end
      ack = 1'b1;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b0, 4'd0, 16'h0000}) begin
         tests_failed++;
         $display("FAIL enable_drop_ack: got v=%0b e=%0d g=%h want v=0 e=0 g=0000",
                  valid, enc_out, grant);
      end
      ack = 1'b0;
   endtask

   // ptr is 15 here (last rr ack advanced it past 14), so a grant of 0
   // after reset shows the pointer was cleared.
   task automatic test_reset_mid();
      mode = 1'b1; enable = 1'b1; ack = 1'b0; in = 16'h8001;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd15, 16'h8000}) begin
         tests_failed++;
         $display("FAIL reset_mid_pre: got v=%0b e=%0d g=%h want v=1 e=15 g=8000",
                  valid, enc_out, grant);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b0, 4'd0, 16'h0000}) begin
         tests_failed++;
         $display("FAIL reset_mid_async: got v=%0b e=%0d g=%h want v=0 e=0 g=0000",
                  valid, enc_out, grant);
      end
      #2 rst_n = 1'b1;
      step();
      tests_run++;
      if ({valid, enc_out, grant} !== {1'b1, 4'd0, 16'h0001}) begin
         tests_failed++;
         $display("FAIL reset_mid_ptr: got v=%0b e=%0d g=%h want v=1 e=0 g=0001",
                  valid, enc_out, grant);
      end
   endtask

   task automatic test_back_to_back();
      mode = 1'b0; enable = 1'b1; ack = 1'b1; in = 16'h0006;
      for (int c = 0; c < 3; c++) begin
         step();
         tests_run++;
         if ({valid, enc_out, grant} !== {1'b1, 4'd1, 16'h0002}) begin
            tests_failed++;
            $display("FAIL b2b_fixed[%0d]: got v=%0b e=%0d g=%h want v=1 e=1 g=0002",
                     c, valid, enc_out, grant);
         end
      end
      enable = 1'b0;
      step();
      ack = 1'b0;
   endtask

   task automatic test_non_pow2();
      logic [2:0] exp_e [4];
      exp_e[0] = 3'd0; exp_e[1] = 3'd4; exp_e[2] = 3'd0; exp_e[3] = 3'd4;
      mode5 = 1'b1; enable5 = 1'b1; ack5 = 1'b1; in5 = 5'h11;
      for (int c = 0; c < 4; c++) begin
         step();
         tests_run++;
         if ({valid5, enc_out5, grant5} !== {1'b1, exp_e[c], 5'(5'h01 << exp_e[c])}) begin
            tests_failed++;
            $display("FAIL np2_rr[%0d]: got v=%0b e=%0d g=%h want v=1 e=%0d",
                     c, valid5, enc_out5, grant5, exp_e[c]);
         end
      end
      enable5 = 1'b0;
      step();
      tests_run++;
      if ({valid5, enc_out5, grant5} !== {1'b0, 3'd0, 5'h00}) begin
         tests_failed++;
         $display("FAIL np2_release: got v=%0b e=%0d g=%h want v=0 e=0 g=00",
                  valid5, enc_out5, grant5);
      end
      ack5 = 1'b0;
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_fixed();
      test_rr_alternate();
      test_rr_wrap();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      test_non_pow2();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
